// File: rtl/fp_mult_seq.sv
// fp_mult_seq: sequential IEEE-style FP multiplier, shift-add mantissa, RNE rounding.
// Ports: clk/rst_n (async active-low); in_valid/in_ready accept a,b;
//        out_valid/out_ready hand over result and flag_invalid/overflow/underflow/inexact.
module fp_mult_seq #(
  parameter int MB = 23,
  parameter int EB = 8,
  localparam int N = MB + EB + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         flag_invalid,
  output logic         flag_overflow,
  output logic         flag_underflow,
  output logic         flag_inexact
);
  typedef enum logic [2:0] {IDLE, CHECK, MUL, NORM, ROUND, DONE} state_t;
  localparam int CW = $clog2(MB + 1);
  localparam logic [EB+1:0] BIAS = (EB+2)'((1 << (EB - 1)) - 1);
  localparam logic [EB:0] EXP_MAX = (EB+1)'((1 << EB) - 1);
  localparam logic [N-1:0] QNAN = {1'b0, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};
  state_t state_q, state_d;
  logic [N-1:0] a_q, b_q, result_q;
  logic sign_q, guard_q, sticky_q;
  logic [EB+1:0] exp_q;
  logic [MB:0] mcand_q, mplier_q;
  logic [2*MB+1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic [MB-1:0] frac_q;
  logic [3:0] flags_q;
  logic [EB-1:0] ea, eb;
  logic [MB-1:0] ma, mb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign, special, spec_inv;
  logic [N-1:0] spec_res, r_res;
  logic [MB+1:0] psum;
  logic top, n_guard, n_sticky, r_ovf, r_unf;
  logic [MB-1:0] n_frac;
  logic [MB:0] r_sum;
  logic [EB+1:0] r_exp;
  assign ea = a_q[N-2:MB];
  assign eb = b_q[N-2:MB];
  assign ma = a_q[MB-1:0];
  assign mb = b_q[MB-1:0];
  // Denormal inputs are treated as zero.
  assign a_zero = ea == '0;
  assign b_zero = eb == '0;
  assign a_inf = &ea && ma == '0;
  assign b_inf = &eb && mb == '0;
  assign a_nan = &ea && |ma;
  assign b_nan = &eb && |mb;
  always_comb begin
    sign = a_q[N-1] ^ b_q[N-1];
    spec_inv = (a_inf && b_zero) || (b_inf && a_zero);
    special = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    spec_res = (a_nan || b_nan || spec_inv) ? QNAN :
               (a_inf || b_inf) ? {sign, {EB{1'b1}}, {MB{1'b0}}} : {sign, {(N-1){1'b0}}};
    // One shift-add step: add multiplicand into the upper half, then shift right.
    psum = {1'b0, acc_q[2*MB+1:MB+1]} + {1'b0, {(MB+1){mplier_q[0]}} & mcand_q};
    top = acc_q[2*MB+1];
    n_frac = top ? acc_q[2*MB:MB+1] : acc_q[2*MB-1:MB];
    n_guard = top ? acc_q[MB] : acc_q[MB-1];
    n_sticky = top ? |acc_q[MB-1:0] : |acc_q[MB-2:0];
    r_sum = {1'b0, frac_q} + (MB+1)'(guard_q & (sticky_q | frac_q[0]));
    // A carry out of the fraction leaves r_sum[MB-1:0] at zero and bumps the exponent.
    r_exp = exp_q + (EB+2)'(r_sum[MB]);
    r_ovf = !r_exp[EB+1] && r_exp[EB:0] >= EXP_MAX;
    r_unf = r_exp[EB+1] || r_exp == '0;
    r_res = r_ovf ? {sign_q, {EB{1'b1}}, {MB{1'b0}}} :
            r_unf ? {sign_q, {(N-1){1'b0}}} : {sign_q, r_exp[EB-1:0], r_sum[MB-1:0]};
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = in_valid ? CHECK : IDLE;
      CHECK:   state_d = special ? DONE : MUL;
      MUL:     state_d = cnt_q == CW'(MB) ? NORM : MUL;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      flags_q <= '0;
      sign_q <= 1'b0;
      exp_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      frac_q <= '0;
      guard_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
        end
        CHECK: begin
          sign_q <= sign;
          if (special) begin
            result_q <= spec_res;
            flags_q <= {spec_inv, 3'b000};
          end else begin
            mcand_q <= {1'b1, ma};
            mplier_q <= {1'b1, mb};
            acc_q <= '0;
            cnt_q <= '0;
            exp_q <= {2'b00, ea} + {2'b00, eb} - BIAS;
          end
        end
        MUL: begin
          acc_q <= {psum, acc_q[MB:1]};
          mplier_q <= mplier_q >> 1;
          cnt_q <= cnt_q + 1'b1;
        end
        NORM: begin
          frac_q <= n_frac;
          guard_q <= n_guard;
          sticky_q <= n_sticky;
          exp_q <= exp_q + (EB+2)'(top);
        end
        ROUND: begin
          result_q <= r_res;
          flags_q <= {1'b0, r_ovf, r_unf, r_ovf | r_unf | guard_q | sticky_q};
        end
        DONE: if (out_ready) flags_q <= '0;
        default: ;
      endcase
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign {flag_invalid, flag_overflow, flag_underflow, flag_inexact} = flags_q;
endmodule

// File: tb/tb_fp_mult_seq.sv
// tb_fp_mult_seq: scoreboard bench for fp_mult_seq at default MB=23, EB=8.
module tb_fp_mult_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic in_ready, out_valid, flag_invalid, flag_overflow, flag_underflow, flag_inexact;
  logic [31:0] result;
  logic [3:0] flags;
  typedef struct {logic [31:0] res; logic [3:0] flg; int lat;} exp_t;
  typedef struct {logic [31:0] a; logic [31:0] b; logic [31:0] res; logic [3:0] flg;} vec_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  fp_mult_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
    .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
  );
  assign flags = {flag_invalid, flag_overflow, flag_underflow, flag_inexact};
  always #5 clk = ~clk;
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb);
    a = xa;
    b = xb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic handshake;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    checks++;
    if (result !== 32'h0 || flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_out: result=%h flags=%b want 0/0000", result, flags);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_arith;
    vec_t tv[11] = '{
      '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000},
      '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000},
      '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001},
      '{32'h3F800003, 32'h3F800000, 32'h3F800003, 4'b0000},
      '{32'h3FC00001, 32'h3FC00000, 32'h40100001, 4'b0001},
      '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001},
      '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001},
      '{32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'b0001},
      '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101},
      '{32'h80800000, 32'h00800000, 32'h80000000, 4'b0011},
      '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011}
    };
    for (int i = 0; i < 11; i++) begin
      int lat;
      exp_t e;
      sb.push_back('{tv[i].res, tv[i].flg, 28});
      issue(tv[i].a, tv[i].b);
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL arith_timeout[%0d]: out_valid=%b want 1", i, out_valid);
      end
      checks++;
      if (result !== e.res) begin
        errors++;
        $display("FAIL arith_result[%0d]: got %h want %h", i, result, e.res);
      end
      checks++;
      if (flags !== e.flg) begin
        errors++;
        $display("FAIL arith_flags[%0d]: got %b want %b", i, flags, e.flg);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL arith_latency[%0d]: got %0d want %0d", i, lat, e.lat);
      end
      handshake();
    end
  endtask
  task automatic test_special;
    vec_t tv[8] = '{
      '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},
      '{32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000},
      '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0000},
      '{32'h3F800000, 32'hFFC00000, 32'h7FC00000, 4'b0000},
      '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000},
      '{32'h00000000, 32'hBF800000, 32'h80000000, 4'b0000},
      '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000},
      '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000}
    };
    for (int i = 0; i < 8; i++) begin
      int lat;
      exp_t e;
      sb.push_back('{tv[i].res, tv[i].flg, i == 7 ? 28 : 2});
      issue(tv[i].a, tv[i].b);
      wait_done(lat);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL special_timeout[%0d]: out_valid=%b want 1", i, out_valid);
      end
      checks++;
      if (result !== e.res || flags !== e.flg) begin
        errors++;
        $display("FAIL special_out[%0d]: got %h/%b want %h/%b", i, result, flags, e.res, e.flg);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL special_latency[%0d]: got %0d want %0d", i, lat, e.lat);
      end
      handshake();
    end
  endtask
  task automatic test_backpressure;
    int lat;
    exp_t e;
    sb.push_back('{32'h40400000, 4'b0000, 28});
    issue(32'h3FC00000, 32'h40000000);
    wait_done(lat);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = $urandom;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res || flags !== e.flg) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ov=%b ir=%b res=%h fl=%b want 1/0/%h/%b",
                 i, out_valid, in_ready, result, flags, e.res, e.flg);
      end
    end
    in_valid = 1'b0;
    handshake();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || flags !== 4'h0) begin
      errors++;
      $display("FAIL bp_release: ir=%b ov=%b fl=%b want 1/0/0000", in_ready, out_valid, flags);
    end
    sb.push_back('{32'hC0C00000, 4'b0000, 28});
    issue(32'hC0000000, 32'h40400000);
    wait_done(lat);
    e = sb.pop_front();
    checks++;
    if (result !== e.res || lat !== e.lat) begin
      errors++;
      $display("FAIL bp_next: got %h lat %0d want %h lat %0d", result, lat, e.res, e.lat);
    end
    handshake();
  endtask
  task automatic test_back_to_back;
    int lat;
    exp_t e;
    sb.push_back('{32'h7F800000, 4'b0101, 28});
    sb.push_back('{32'h7F7FFFFF, 4'b0000, 28});
    issue(32'h7F7FFFFF, 32'h40000000);
    wait_done(lat);
    e = sb.pop_front();
    checks++;
    if (result !== e.res || flags !== e.flg) begin
      errors++;
      $display("FAIL b2b_first: got %h/%b want %h/%b", result, flags, e.res, e.flg);
    end
    handshake();
    issue(32'h7F7FFFFF, 32'h3F800000);
    wait_done(lat);
    e = sb.pop_front();
    checks++;
    if (result !== e.res || flags !== e.flg || lat !== e.lat) begin
      errors++;
      $display("FAIL b2b_second: got %h/%b lat %0d want %h/%b lat %0d",
               result, flags, lat, e.res, e.flg, e.lat);
    end
    handshake();
  endtask
  task automatic test_reset_mid;
    int lat;
    exp_t e;
    issue(32'h3FC00000, 32'h40000000);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0 || flags !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset: ov=%b ir=%b res=%h fl=%b want 0/1/0/0000",
               out_valid, in_ready, result, flags);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_abort: ov=%b ir=%b want 0/1", out_valid, in_ready);
    end
    sb.push_back('{32'h40400000, 4'b0000, 28});
    issue(32'h3FC00000, 32'h40000000);
    wait_done(lat);
    e = sb.pop_front();
    checks++;
    if (result !== e.res || flags !== e.flg || lat !== e.lat) begin
      errors++;
      $display("FAIL mid_fresh: got %h/%b lat %0d want %h/%b lat %0d",
               result, flags, lat, e.res, e.flg, e.lat);
    end
    handshake();
  endtask
  initial begin
    test_reset();
    test_arith();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
